grant_arbiter: RTL and testbench

Arbiter that shares one downstream resource among 2^n requesters. It uses a priority-encoded winner search, a registered one-hot grant, and a hold-time limit. A grant stays with its owner until the owner releases it or is preempted. The block sits in front of any shared datapath, such as a bus port or a shared ALU, and drives that resource's select lines from `grant_id`.

---
 rtl/arb_pkg.sv | 15 +
 rtl/prio_enc_rot.sv | 34 +++
 rtl/grant_arbiter.sv | 177 +++++++++++++++++
 tb/tb_grant_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and default constants for grant_arbiter.
//   arb_state_t  : arbiter FSM state (IDLE = no owner, BUSY = owner held)
//   ARB_N        : default log2 of the requester count
//   ARB_HOLD_MAX : default hold-time limit before preemption (0 disables it)
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int ARB_N        = 3;
  localparam int ARB_HOLD_MAX = 16;

endpackage

// File: rtl/prio_enc_rot.sv
// Rotating priority encoder: finds the first set bit of cand at or after
// index start, wrapping modulo 2^n.
//   cand  : candidate vector, 2^n bits
//   start : index where the search begins
//   idx   : winning index (meaningful only when found = 1)
//   found : cand has at least one set bit
module prio_enc_rot
  import arb_pkg::*;
#(
  parameter int n = ARB_N
) (
  input  logic [(1<<n)-1:0] cand,
  input  logic [n-1:0]      start,
  output logic [n-1:0]      idx,
  output logic              found
);

  localparam int N = 1 << n;

  logic [N-1:0] rot;
  logic [n-1:0] k;

  always_comb begin
    // rot[i] is the candidate i positions after start; n-bit add wraps.
    rot = '0;
    for (int i = 0; i < N; i++) rot[i] = cand[n'(i) + start];
    // Descending scan so the lowest set position is the one that sticks.
    k = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) k = n'(i);
    found = |cand;
    idx   = k + start;
  end

endmodule

// File: rtl/grant_arbiter.sv
// grant_arbiter: shares one downstream resource among 2^n requesters with a
// registered one-hot grant, direct handoff on release, and preemption of an
// owner that has held the grant HOLD_MAX+1 cycles while others wait.
//
// Build option: define GRANT_ARB_ROUND_ROBIN_EN for a round-robin winner
// search starting after the last winner; otherwise the highest requesting
// index wins (fixed priority).
//
// Ports:
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   req         : request vector, bit i held while requester i wants/owns
//   grant       : registered one-hot grant (zero when idle)
//   grant_id    : binary owner index, valid with grant_valid
//   grant_valid : resource owned this cycle
//   preempt     : one-cycle pulse on the first cycle of a timeout handoff
module grant_arbiter
  import arb_pkg::*;
#(
  parameter int n        = ARB_N,
  parameter int HOLD_MAX = ARB_HOLD_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [(1<<n)-1:0] req,
  output logic [(1<<n)-1:0] grant,
  output logic [n-1:0]      grant_id,
  output logic              grant_valid,
  output logic              preempt
);

  localparam int N  = 1 << n;
  // Keep at least one counter bit so HOLD_MAX = 0 still elaborates.
  localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

  arb_state_t    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [n-1:0]  id_q, id_d;
  logic          valid_q, valid_d;
  logic          pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  cand;
  logic [n-1:0]  win_idx, enc_idx;
  logic          found;
  logic          owner_req, waiting, hold_hit;
  logic          take, take_pre;

  // ---------------------------------------------------------------------
  // Winner search. The owner's bit is always masked: in IDLE grant_q is
  // zero, and in BUSY a new winner is only taken on handoff/preemption.
  // ---------------------------------------------------------------------
  assign cand = req & ~grant_q;

`ifdef GRANT_ARB_ROUND_ROBIN_EN
  logic [n-1:0] ptr_q, ptr_d, ptr_start;

  assign ptr_start = ptr_q + 1'b1;

  prio_enc_rot #(.n(n)) u_enc (
    .cand  (cand),
    .start (ptr_start),
    .idx   (enc_idx),
    .found (found)
  );
  assign win_idx = enc_idx;

  always_comb begin
    ptr_d = ptr_q;
    if (take) ptr_d = win_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '1;
    else        ptr_q <= ptr_d;
  end
`else
  // Fixed priority: bit-reverse so the lowest-first encoder picks the
  // highest set index.
  logic [N-1:0] cand_rev;

  for (genvar i = 0; i < N; i++) begin : g_rev
    assign cand_rev[i] = cand[N-1-i];
  end

  prio_enc_rot #(.n(n)) u_enc (
    .cand  (cand_rev),
    .start ('0),
    .idx   (enc_idx),
    .found (found)
  );
  assign win_idx = n'(N - 1) - enc_idx;
`endif

  assign owner_req = req[id_q];
  assign waiting   = |cand;
  assign hold_hit  = (HOLD_MAX != 0) && (cnt_q == CW'(HOLD_MAX));

  // ---------------------------------------------------------------------
  // State register (all arbiter state).
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      pre_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next state: decides whether a new winner is taken this edge.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    take_pre = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          take    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!owner_req) begin
          if (found) take    = 1'b1;   // direct handoff, no idle cycle
          else       state_d = IDLE;
        end else if (hold_hit && waiting) begin
          take     = 1'b1;
          take_pre = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs / datapath next values.
  // ---------------------------------------------------------------------
  always_comb begin
    grant_d = grant_q;
    id_d    = id_q;
    valid_d = valid_q;
    pre_d   = 1'b0;
    cnt_d   = cnt_q;
    if (take) begin
      grant_d = N'(1) << win_idx;
      id_d    = win_idx;
      valid_d = 1'b1;
      pre_d   = take_pre;
      cnt_d   = '0;
    end else if (state_d == IDLE) begin
      grant_d = '0;
      id_d    = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (cnt_q != CW'(HOLD_MAX)) begin
      cnt_d = cnt_q + 1'b1;          // saturates at HOLD_MAX
    end
  end

  assign grant       = grant_q;
  assign grant_id    = id_q;
  assign grant_valid = valid_q;
  assign preempt     = pre_q;

endmodule

// File: tb/tb_grant_arbiter.sv
module tb_grant_arbiter;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] id;
    logic       v;
    logic       p;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       preempt;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  grant_arbiter #(.n(3), .HOLD_MAX(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .preempt     (preempt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want finish before timeout");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input int id, input logic v, input logic p);
    exp_t e;
    e.g  = v ? (8'h01 << id) : 8'h00;
    e.id = v ? 3'(id) : 3'd0;
    e.v  = v;
    e.p  = p;
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t o;
    o.g  = grant;
    o.id = grant_valid ? grant_id : 3'd0;
    o.v  = grant_valid;
    o.p  = preempt;
    return o;
  endfunction

  // Drive req for the next edge and queue what must be seen after it.
  task automatic step(input logic [7:0] r, input exp_t e);
    req = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

`ifdef GRANT_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  task automatic test_reset();
    exp_t got, want;
    rst_n = 1'b0;
    for (int j = 0; j < 2; j++) begin
      step(8'hFF, mk(0, 0, 0));
      got = obs(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset edge%0d: got %h want %h", j, got, want);
      end
    end
    rst_n = 1'b1;
    step(8'h00, mk(0, 0, 0));
    got = obs(); want = sb.pop_front(); n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h", got, want);
    end
  endtask

  task automatic test_single();
    exp_t got, want;
    do_reset();
    for (int j = 0; j < 5; j++) begin
      if (j < 4) step(8'h20, mk(5, 1, 0));
      else       step(8'h00, mk(0, 0, 0));
      got = obs(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL single edge%0d: got %h want %h", j + 1, got, want);
      end
    end
  endtask

  task automatic test_rotation();
    exp_t got, want;
    logic [7:0] r;
    int ord[4];
    do_reset();
    for (int i = 0; i < 4; i++) ord[i] = RR ? i : 3 - i;
    r = 8'h0F;
    for (int j = 0; j < 9; j++) begin
      if (j < 8) step(r, mk(ord[j/2], 1, 0));
      else       step(r, mk(0, 0, 0));
      got = obs(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL rotation edge%0d: got %h want %h", j + 1, got, want);
      end
      if (j < 8 && (j % 2) == 1) r[ord[j/2]] = 1'b0;
    end
  endtask

  task automatic test_preempt();
    exp_t got, want;
    int a, b;
    do_reset();
    a = RR ? 1 : 6;
    b = RR ? 6 : 1;
    for (int j = 0; j < 12; j++) begin
      step(8'h42, mk((j < 5 || j >= 10) ? a : b, 1, (j == 5 || j == 10)));
      got = obs(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL preempt edge%0d: got %h want %h", j + 1, got, want);
      end
    end
  endtask

  task automatic test_lone();
    exp_t got, want;
    do_reset();
    for (int j = 0; j < 20; j++) begin
      step(8'h08, mk(3, 1, 0));
      got = obs(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL lone edge%0d: got %h want %h", j + 1, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t got, want;
    logic [7:0] rv[5];
    exp_t ev[5];
    do_reset();
    // release+new request together, then a non-owner drops its request
    rv = '{8'h01, 8'h80, 8'h81, 8'h80, 8'h00};
    ev[0] = mk(0, 1, 0); ev[1] = mk(7, 1, 0); ev[2] = mk(7, 1, 0);
    ev[3] = mk(7, 1, 0); ev[4] = mk(0, 0, 0);
    for (int j = 0; j < 5; j++) begin
      step(rv[j], ev[j]);
      got = obs(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back edge%0d: got %h want %h", j + 1, got, want);
      end
    end
  endtask

  task automatic test_midreset();
    exp_t got, want;
    do_reset();
    step(8'h08, mk(3, 1, 0));
    got = obs(); want = sb.pop_front(); n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL midreset_grant: got %h want %h", got, want);
    end
    rst_n = 1'b0;
    step(8'h09, mk(0, 0, 0));
    got = obs(); want = sb.pop_front(); n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL midreset_clear: got %h want %h", got, want);
    end
    rst_n = 1'b1;
    for (int j = 0; j < 2; j++) begin
      step(8'h09, mk(RR ? 0 : 3, 1, 0));
      got = obs(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL midreset_after edge%0d: got %h want %h", j + 1, got, want);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_rotation();
    test_preempt();
    test_lone();
    test_back_to_back();
    test_midreset();
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
